// File: rtl/rpn_engine.sv
// rpn_engine: evaluates integer RPN expressions from a uart_rx byte stream,
// emitting one result or error pulse per line terminator.
module rpn_engine #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_ready,
    output logic [WIDTH-1:0]           result,
    output logic                       result_valid,
    output logic                       result_err,
    output logic [$clog2(DEPTH):0]     depth
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, FLUSH, EXEC} state_t;

    state_t                      state_q, state_d;
    logic [WIDTH-1:0]            acc_q, acc_d;
    logic                        num_q, num_d;
    logic                        err_q, err_d;
    logic                        ready_q;
    logic [7:0]                  op_q, op_d;
    logic [DEPTH-1:0][WIDTH-1:0] stk_q, stk_d;
    logic [PW-1:0]               ptr_q, ptr_d;
    logic [WIDTH-1:0]            result_q, result_d;
    logic                        rv_q, rv_d, re_q, re_d;
    logic [AW-1:0]               top_i, nxt_i;
    logic [WIDTH-1:0]            x, y, alu;
    logic                        byte_ev, is_digit, is_tok, is_term;

    assign byte_ev  = rx_ready && !ready_q && state_q == IDLE;
    assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
    assign is_tok   = rx_data == 8'h20 || rx_data == 8'h2B || rx_data == 8'h2D || rx_data == 8'h2A
                   || rx_data == 8'h3D || rx_data == 8'h0D || rx_data == 8'h0A;
    assign is_term  = op_q == 8'h3D || op_q == 8'h0D || op_q == 8'h0A;
    assign top_i    = ptr_q[AW-1:0] - AW'(1);
    assign nxt_i    = ptr_q[AW-1:0] - AW'(2);
    assign x        = stk_q[top_i];
    assign y        = stk_q[nxt_i];
    assign alu      = op_q == 8'h2B ? y + x : op_q == 8'h2D ? y - x : y * x;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        num_d    = num_q;
        err_d    = err_q;
        op_d     = op_q;
        stk_d    = stk_q;
        ptr_d    = ptr_q;
        result_d = result_q;
        rv_d     = 1'b0;
        re_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (byte_ev && is_digit) begin
                    acc_d = acc_q * WIDTH'(10) + WIDTH'(rx_data[3:0]);
                    num_d = 1'b1;
                end else if (byte_ev && is_tok) begin
                    op_d    = rx_data;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (num_q && ptr_q == PW'(DEPTH)) begin
                    err_d = 1'b1;
                end else if (num_q) begin
                    stk_d[ptr_q[AW-1:0]] = acc_q;
                    ptr_d = ptr_q + PW'(1);
                end
                acc_d   = '0;
                num_d   = 1'b0;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = IDLE;
                if (is_term) begin
                    rv_d     = !err_q && ptr_q != '0;
                    re_d     = !rv_d;
                    result_d = rv_d ? x : result_q;
                    ptr_d    = '0;
                    err_d    = 1'b0;
                end else if (op_q != 8'h20 && ptr_q < PW'(2)) begin
                    err_d = 1'b1;
                end else if (op_q != 8'h20) begin
                    stk_d[nxt_i] = alu;
                    ptr_d = ptr_q - PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ready_q resets high so a level held across reset release is not a byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            num_q    <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            op_q     <= '0;
            stk_q    <= '0;
            ptr_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            re_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            num_q    <= num_d;
            err_q    <= err_d;
            ready_q  <= rx_ready;
            op_q     <= op_d;
            stk_q    <= stk_d;
            ptr_q    <= ptr_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            re_q     <= re_d;
        end
    end

    assign result       = result_q;
    assign result_valid = rv_q;
    assign result_err   = re_q;
    assign depth        = ptr_q;
endmodule
